// File: rtl/piano_key_scanner.sv
// Keyboard input front end: synchronizes and debounces seven note keys and two
// octave switches, then tracks the sounding note with a last-pressed-wins policy.
module piano_key_scanner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit RAW_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] note_keys_raw,
    input  logic       octave_up_raw,
    input  logic       octave_down_raw,
    output logic [2:0] current_active_key_id,
    output logic       current_key_is_pressed_flag,
    output logic       octave_up_active,
    output logic       octave_down_active,
    output logic       note_change_pulse
);

    localparam int NUM_CH = 9;
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channels 0..6 are the note keys, 7 is SW15 (up), 8 is SW13 (down).
    logic [NUM_CH-1:0] raw_in;
    logic [NUM_CH-1:0] sync_meta;
    logic [NUM_CH-1:0] sync_q;
    logic [NUM_CH-1:0] db;
    logic [CNT_W-1:0]  cnt [NUM_CH];

    assign raw_in = RAW_ACTIVE_LOW ? ~{octave_down_raw, octave_up_raw, note_keys_raw}
                                   :  {octave_down_raw, octave_up_raw, note_keys_raw};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= '0;
            sync_q    <= '0;
            db        <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_meta <= raw_in;
            sync_q    <= sync_meta;
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync_q[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    db[i]  <= ~db[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    logic [6:0] db_note;
    logic [6:0] db_note_d;
    logic [6:0] press_edge;
    logic [2:0] pressed_id;
    logic [2:0] held_id;
    logic       active_released;
    logic [2:0] next_id;

    assign db_note    = db[6:0];
    assign press_edge = db_note & ~db_note_d;

    // Descending scan so the lowest-index match is the one that sticks.
    always_comb begin
        pressed_id      = '0;
        held_id         = '0;
        active_released = 1'b0;
        for (int k = 6; k >= 0; k--) begin
            if (press_edge[k]) begin
                pressed_id = 3'(k + 1);
            end
            if (db_note[k]) begin
                held_id = 3'(k + 1);
            end
            if ((current_active_key_id == 3'(k + 1)) && !db_note[k]) begin
                active_released = 1'b1;
            end
        end
        next_id = current_active_key_id;
        if (|press_edge) begin
            next_id = pressed_id;
        end else if (active_released) begin
            next_id = held_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_note_d                   <= '0;
            current_active_key_id       <= '0;
            current_key_is_pressed_flag <= 1'b0;
            note_change_pulse           <= 1'b0;
            octave_up_active            <= 1'b0;
            octave_down_active          <= 1'b0;
        end else begin
            db_note_d                   <= db_note;
            current_active_key_id       <= next_id;
            current_key_is_pressed_flag <= (next_id != 3'd0);
            note_change_pulse           <= (next_id != current_active_key_id);
            octave_up_active            <= db[7];
            octave_down_active          <= db[8];
        end
    end

endmodule
